// File: rtl/package_settings.sv
// Shared data-path sizing for the v11 filter chain.
package package_settings;
  localparam int SIZE_FILTER_DATA = 15;
endpackage

// File: rtl/v11_pha_parameters.sv
// Pulse height analyzer constants, FSM state type and saturating counter helper.
package v11_pha_parameters;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLDOFF = 2'd2
  } pha_state_e;

  localparam int DEF_WINDOW   = 16;
  localparam int DEF_HOLDOFF  = 8;
  localparam int DEF_TS_WIDTH = 32;

  localparam logic [7:0] CNT_SAT = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/v11_pha_output_reg.sv
// Single-entry valid/ready result register; results arriving while it is
// full and not draining are dropped and counted.
module v11_pha_output_reg
  import v11_pha_parameters::*;
#(
  parameter int D_W  = 16,
  parameter int TS_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [D_W-1:0]  in_amp,
  input  logic [TS_W-1:0] in_ts,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [D_W-1:0]  out_amp,
  output logic [TS_W-1:0] out_ts,
  output logic [7:0]      lost_count
);
  logic            valid_q, valid_d, xfer;
  logic [D_W-1:0]  amp_q, amp_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      lost_q, lost_d;

  always_comb begin
    xfer    = valid_q && out_ready;
    valid_d = valid_q;
    amp_d   = amp_q;
    ts_d    = ts_q;
    lost_d  = lost_q;
    if (xfer) valid_d = 1'b0;
    // A result landing on the same cycle as a transfer replaces the old one.
    if (load) begin
      if (valid_q && !xfer) begin
        lost_d = sat_inc(lost_q);
      end else begin
        valid_d = 1'b1;
        amp_d   = in_amp;
        ts_d    = in_ts;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      amp_q   <= '0;
      ts_q    <= '0;
      lost_q  <= '0;
    end else begin
      valid_q <= valid_d;
      amp_q   <= amp_d;
      ts_q    <= ts_d;
      lost_q  <= lost_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_amp    = amp_q;
  assign out_ts     = ts_q;
  assign lost_count = lost_q;
endmodule

// File: rtl/v11_pulse_height_analyzer.sv
// Threshold-triggered peak capture over a fixed window with holdoff and timestamping.
// Optional pile-up rejection is enabled by defining V11_PHA_PILEUP_REJECT_EN.
module v11_pulse_height_analyzer
  import package_settings::*;
#(
  parameter int WINDOW   = v11_pha_parameters::DEF_WINDOW,
  parameter int HOLDOFF  = v11_pha_parameters::DEF_HOLDOFF,
  parameter int TS_WIDTH = v11_pha_parameters::DEF_TS_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SIZE_FILTER_DATA:0] filter_data,
  input  logic [SIZE_FILTER_DATA:0] threshold,
  output logic [SIZE_FILTER_DATA:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]       peak_timestamp,
  output logic                      peak_valid,
  input  logic                      peak_ready,
  output logic [7:0]                lost_count,
  output logic [7:0]                pileup_count
);
  import v11_pha_parameters::pha_state_e;
  import v11_pha_parameters::sat_inc;

  localparam int DW = SIZE_FILTER_DATA + 1;
  localparam pha_state_e ST_IDLE = v11_pha_parameters::IDLE;
  localparam pha_state_e ST_MEAS = v11_pha_parameters::MEASURE;
  localparam pha_state_e ST_HOLD = v11_pha_parameters::HOLDOFF;
  localparam logic [7:0] WIN_LAST  = 8'(WINDOW);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic signed [DW-1:0] samp_q, thr_q, thr_d, thr_eff, max_q, max_d;
  logic [TS_WIDTH-1:0]  ts_cnt_q, ts_cnt_d, samp_ts_q, ev_ts_q, ev_ts_d;
  logic                 samp_vld_q, above, emit;
  pha_state_e           state_q, state_d;
  logic [7:0]           win_q, win_d, hold_q, hold_d;
`ifdef V11_PHA_PILEUP_REJECT_EN
  logic                 below_q, below_d, pile_q, pile_d, pile_hit;
  logic [7:0]           pile_cnt_q, pile_cnt_d;
`endif

  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
    // Live threshold is used and tracked only in IDLE; events see a frozen copy.
    thr_eff  = (state_q == ST_IDLE) ? $signed(threshold) : thr_q;
    thr_d    = thr_eff;
    above    = samp_q > thr_eff;
    state_d  = state_q;
    max_d    = max_q;
    ev_ts_d  = ev_ts_q;
    win_d    = win_q;
    hold_d   = hold_q;
    emit     = 1'b0;
`ifdef V11_PHA_PILEUP_REJECT_EN
    below_d  = below_q;
    pile_d   = pile_q;
    pile_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (samp_vld_q && above) begin
          state_d = ST_MEAS;
          ev_ts_d = samp_ts_q;
          max_d   = samp_q;
          win_d   = 8'd1;
`ifdef V11_PHA_PILEUP_REJECT_EN
          below_d = 1'b0;
          pile_d  = 1'b0;
`endif
        end
      end
      ST_MEAS: begin
        if (win_q == WIN_LAST) begin
          state_d = ST_HOLD;
          hold_d  = 8'd0;
`ifdef V11_PHA_PILEUP_REJECT_EN
          if (pile_q) pile_hit = 1'b1;
          else        emit     = 1'b1;
`else
          emit = 1'b1;
`endif
        end else begin
          win_d = win_q + 8'd1;
          if (samp_q > max_q) max_d = samp_q;
`ifdef V11_PHA_PILEUP_REJECT_EN
          if (!above)       below_d = 1'b1;
          else if (below_q) pile_d  = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (hold_q >= HOLD_LAST && !above) state_d = ST_IDLE;
        else if (hold_q != 8'hff)          hold_d  = hold_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q     <= '0;
      samp_ts_q  <= '0;
      samp_vld_q <= 1'b0;
      ts_cnt_q   <= '0;
      thr_q      <= '0;
      state_q    <= ST_IDLE;
      max_q      <= '0;
      ev_ts_q    <= '0;
      win_q      <= '0;
      hold_q     <= '0;
    end else begin
      samp_q     <= $signed(filter_data);
      samp_ts_q  <= ts_cnt_q;
      samp_vld_q <= 1'b1;
      ts_cnt_q   <= ts_cnt_d;
      thr_q      <= thr_d;
      state_q    <= state_d;
      max_q      <= max_d;
      ev_ts_q    <= ev_ts_d;
      win_q      <= win_d;
      hold_q     <= hold_d;
    end
  end

`ifdef V11_PHA_PILEUP_REJECT_EN
  always_comb pile_cnt_d = pile_hit ? sat_inc(pile_cnt_q) : pile_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      below_q    <= 1'b0;
      pile_q     <= 1'b0;
      pile_cnt_q <= '0;
    end else begin
      below_q    <= below_d;
      pile_q     <= pile_d;
      pile_cnt_q <= pile_cnt_d;
    end
  end

  assign pileup_count = pile_cnt_q;
`else
  assign pileup_count = 8'd0;
`endif

  v11_pha_output_reg #(.D_W(DW), .TS_W(TS_WIDTH)) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (emit),
    .in_amp     (max_q),
    .in_ts      (ev_ts_q),
    .out_ready  (peak_ready),
    .out_valid  (peak_valid),
    .out_amp    (peak_amplitude),
    .out_ts     (peak_timestamp),
    .lost_count (lost_count)
  );
endmodule
